// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with registered ready,
// synchronous flush that clears control fields, and NOP-on-bubble control output.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_ready_o is a flop so
  // out_ready_i has no combinational path back upstream.

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;
  logic [1:0]        occupancy_q,  occupancy_d;

  logic accept;
  logic emit;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    accept = in_valid_i & in_ready_q;
    emit   = main_valid_q & out_ready_i;

    if (flush_i) begin
      // Flush wins over everything; payload is left as-is, only control is zeroed.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = ctrl_i;
        main_data_d  = data_i;
      end
    end else if (emit) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = ctrl_i;
        main_data_d  = data_i;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = ctrl_i;
      skid_data_d  = data_i;
    end

    in_ready_d  = ~skid_valid_d;
    occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      occupancy_q  <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      occupancy_q  <= occupancy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_valid_q;
  assign ctrl_o      = main_ctrl_q;
  assign data_o      = main_data_q;
  assign occupancy_o = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, streaming, flush, async
// reset between edges, and a long random run against a queue-based model.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 96;
  localparam int EW = CW + DW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [1:0]    occupancy_o;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ctrl_o      (ctrl_o),
    .data_o      (data_o),
    .occupancy_o (occupancy_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // scoreboard: accepted entries in order, head is what the DUT must present
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic          iv;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          e_ov;
    logic [CW-1:0] e_ctrl;
    logic [DW-1:0] e_data;
    logic [1:0]    e_occ;
    logic          e_ir;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic iv, logic [CW-1:0] c, logic [DW-1:0] d, logic ordy,
                              logic fl, logic e_ov, logic [CW-1:0] e_ctrl,
                              logic [DW-1:0] e_data, logic [1:0] e_occ, logic e_ir);
    vec_t v;
    v.iv = iv; v.c = c; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_ctrl = e_ctrl; v.e_data = e_data; v.e_occ = e_occ; v.e_ir = e_ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_out_valid", 128'(out_valid_o), 128'(exp_q.size() > 0));
    chk("model_in_ready", 128'(in_ready_o), 128'(exp_q.size() < 2));
    chk("model_occupancy", 128'(occupancy_o), 128'(exp_q.size()));
    if (exp_q.size() == 0) chk("bubble_ctrl_zero", 128'(ctrl_o), 128'd0);
    else chk("model_head", 128'({ctrl_o, data_o}), 128'(exp_q[0]));
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic cycle(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    logic          emit_m;
    logic          accept_m;
    logic [EW-1:0] head;
    check_model();
    in_valid_i  = iv;
    ctrl_i      = c;
    data_i      = d;
    out_ready_i = ordy;
    flush_i     = fl;
    emit_m   = (exp_q.size() > 0) && ordy;
    accept_m = iv && (exp_q.size() < 2) && !fl;
    #1;
    if (emit_m) begin
      head = exp_q.pop_front();
      chk("emit_data", 128'({ctrl_o, data_o}), 128'(head));
    end
    @(posedge clk_i);
    if (fl) exp_q.delete();
    else if (accept_m) exp_q.push_back({c, d});
    @(negedge clk_i);
  endtask

  initial begin
    vecs[0]  = mk(1, 8'h5A, 96'd1, 1, 0,  1, 8'h5A, 96'd1, 2'd1, 1);
    vecs[1]  = mk(0, 8'h00, 96'd0, 1, 0,  0, 8'h00, 96'd0, 2'd0, 1);
    vecs[2]  = mk(1, 8'h11, 96'hA, 0, 0,  1, 8'h11, 96'hA, 2'd1, 1);
    vecs[3]  = mk(1, 8'h22, 96'hB, 0, 0,  1, 8'h11, 96'hA, 2'd2, 0);
    vecs[4]  = mk(1, 8'h33, 96'hC, 0, 0,  1, 8'h11, 96'hA, 2'd2, 0);
    vecs[5]  = mk(0, 8'h00, 96'd0, 1, 0,  1, 8'h22, 96'hB, 2'd1, 1);
    vecs[6]  = mk(0, 8'h00, 96'd0, 1, 0,  0, 8'h00, 96'd0, 2'd0, 1);
    vecs[7]  = mk(1, 8'h44, 96'd4, 0, 0,  1, 8'h44, 96'd4, 2'd1, 1);
    vecs[8]  = mk(1, 8'h55, 96'd5, 0, 0,  1, 8'h44, 96'd4, 2'd2, 0);
    vecs[9]  = mk(1, 8'h66, 96'd6, 1, 1,  0, 8'h00, 96'd0, 2'd0, 1);
    vecs[10] = mk(0, 8'h00, 96'd0, 1, 0,  0, 8'h00, 96'd0, 2'd0, 1);
    vecs[11] = mk(1, 8'h77, 96'd7, 1, 0,  1, 8'h77, 96'd7, 2'd1, 1);
    vecs[12] = mk(1, 8'h88, 96'd8, 0, 0,  1, 8'h77, 96'd7, 2'd2, 0);
    vecs[13] = mk(0, 8'h00, 96'd0, 1, 0,  1, 8'h88, 96'd8, 2'd1, 1);
    vecs[14] = mk(1, 8'h99, 96'd9, 1, 0,  1, 8'h99, 96'd9, 2'd1, 1);
    vecs[15] = mk(0, 8'h00, 96'd0, 0, 0,  1, 8'h99, 96'd9, 2'd1, 1);
    vecs[16] = mk(0, 8'h00, 96'd0, 1, 0,  0, 8'h00, 96'd0, 2'd0, 1);

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    ctrl_i = '0; data_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_out_valid", 128'(out_valid_o), 128'd0);
    chk("rst_in_ready", 128'(in_ready_o), 128'd1);
    chk("rst_occupancy", 128'(occupancy_o), 128'd0);
    chk("rst_ctrl", 128'(ctrl_o), 128'd0);
    chk("rst_data", 128'(data_o), 128'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // directed table
    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].iv, vecs[i].c, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d_out_valid", i), 128'(out_valid_o), 128'(vecs[i].e_ov));
      chk($sformatf("vec%0d_ctrl", i), 128'(ctrl_o), 128'(vecs[i].e_ctrl));
      chk($sformatf("vec%0d_occ", i), 128'(occupancy_o), 128'(vecs[i].e_occ));
      chk($sformatf("vec%0d_in_ready", i), 128'(in_ready_o), 128'(vecs[i].e_ir));
      if (vecs[i].e_ov) chk($sformatf("vec%0d_data", i), 128'(data_o), 128'(vecs[i].e_data));
    end

    // streaming at full rate
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, CW'(8'h80 + i), {$urandom, $urandom, $urandom}, 1'b1, 1'b0);
      chk("stream_in_ready", 128'(in_ready_o), 128'd1);
      chk("stream_occ", 128'(occupancy_o), 128'd1);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // async reset between edges at occupancy 2
    cycle(1'b1, 8'hC1, 96'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 96'hC2, 1'b0, 1'b0);
    chk("pre_rst_occ", 128'(occupancy_o), 128'd2);
    in_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_out_valid", 128'(out_valid_o), 128'd0);
    chk("async_rst_ctrl", 128'(ctrl_o), 128'd0);
    chk("async_rst_data", 128'(data_o), 128'd0);
    chk("async_rst_occ", 128'(occupancy_o), 128'd0);
    chk("async_rst_in_ready", 128'(in_ready_o), 128'd1);
    rst_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    cycle(1'b1, 8'hD5, 96'hD5, 1'b0, 1'b0);
    chk("post_rst_latency_valid", 128'(out_valid_o), 128'd1);
    chk("post_rst_latency_data", 128'(data_o), 128'hD5);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), CW'($urandom), {$urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check_model();
    chk("final_empty", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
